// File: rtl/vc_buffer_ram.sv
// vc_buffer_ram
//   Multi-virtual-channel input buffer. One storage array is split into NUM_VC
//   circular FIFOs of VC_DEPTH flits each, addressed as {vc, ptr}. Per-VC write
//   pointer, read pointer and occupancy count are kept here, so the allocator
//   only names a VC. One write and one read may be accepted per cycle.
//
//   Optional feature macro: VC_BUF_RD_HOLD_EN
//     undefined : rd_data returns to 0 on any cycle without an accepted read.
//     defined   : rd_data keeps its last read value until the next accepted read.
//
// Ports
//   wr_clk    in   sole clock for both ports
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   write request
//   wr_vc     in   [VCW]         target VC of the write
//   wr_data   in   [DATA_WIDTH]  flit to store
//   rd_en     in   read request
//   rd_vc     in   [VCW]         source VC of the read
//   rd_data   out  [DATA_WIDTH]  registered read data
//   rd_valid  out  rd_data holds an accepted read
//   vc_full   out  [NUM_VC]      count[v] == VC_DEPTH
//   vc_empty  out  [NUM_VC]      count[v] == 0
//   vc_count  out  [NUM_VC*CW]   packed counts, VC v at [v*CW +: CW]
//   err_ovf   out  one-cycle pulse after a rejected write
//   err_udf   out  one-cycle pulse after a rejected read
module vc_buffer_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned VC_DEPTH   = 4,
    localparam int unsigned VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int unsigned PW  = $clog2(VC_DEPTH),
    localparam int unsigned CW  = $clog2(VC_DEPTH + 1)
) (
    input  logic                   wr_clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [VCW-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [VCW-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic [NUM_VC-1:0]      vc_full,
    output logic [NUM_VC-1:0]      vc_empty,
    output logic [NUM_VC*CW-1:0]   vc_count,
    output logic                   err_ovf,
    output logic                   err_udf
);

    localparam int unsigned Words = NUM_VC * VC_DEPTH;

    logic [DATA_WIDTH-1:0] mem [Words];

    logic [PW-1:0] wr_ptr_q [NUM_VC];
    logic [PW-1:0] wr_ptr_d [NUM_VC];
    logic [PW-1:0] rd_ptr_q [NUM_VC];
    logic [PW-1:0] rd_ptr_d [NUM_VC];
    logic [CW-1:0] count_q  [NUM_VC];
    logic [CW-1:0] count_d  [NUM_VC];

    logic              wr_ok;
    logic              rd_ok;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;
    logic [VCW+PW-1:0] wr_addr;
    logic [VCW+PW-1:0] rd_addr;

    // Status comes only from registered counts.
    always_comb begin
        vc_full  = '0;
        vc_empty = '0;
        vc_count = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            vc_full[v]           = (count_q[v] == CW'(VC_DEPTH));
            vc_empty[v]          = (count_q[v] == '0);
            vc_count[v*CW +: CW] = count_q[v];
        end
    end

    // Range check first so an out-of-range index never selects a status bit.
    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        if (wr_en && (32'(wr_vc) < NUM_VC)) begin
            wr_ok = !vc_full[wr_vc];
        end
        if (rd_en && (32'(rd_vc) < NUM_VC)) begin
            rd_ok = !vc_empty[rd_vc];
        end
    end

    always_comb begin
        wr_addr = '0;
        rd_addr = '0;
        if (wr_ok) begin
            wr_addr = {wr_vc, wr_ptr_q[wr_vc]};
        end
        if (rd_ok) begin
            rd_addr = {rd_vc, rd_ptr_q[rd_vc]};
        end
    end

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            wr_hit[v]   = wr_ok && (wr_vc == VCW'(v));
            rd_hit[v]   = rd_ok && (rd_vc == VCW'(v));
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            count_d[v]  = count_q[v];
            if (wr_hit[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
            end
            if (rd_hit[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
            end
            // Simultaneous write and read on one VC leaves the count alone.
            if (wr_hit[v] && !rd_hit[v]) begin
                count_d[v] = count_q[v] + CW'(1);
            end else if (!wr_hit[v] && rd_hit[v]) begin
                count_d[v] = count_q[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
            end
        end
    end

    // Storage is never reset. A read and an accepted write can never share an
    // address: reads need a non-empty VC, writes need a non-full one.
    always_ff @(posedge wr_clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            err_ovf  <= wr_en && !wr_ok;
            err_udf  <= rd_en && !rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_addr];
            end else begin
`ifdef VC_BUF_RD_HOLD_EN
                rd_data <= rd_data;
`else
                rd_data <= '0;
`endif
            end
        end
    end

endmodule
